// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types for the CORDIC sequencer.
//   - state_e : sequencer states (QUAD is only reachable when the
//               CORDIC_CTRL_QUAD_EN macro is defined)
//   - STATE_W : state register width
//   - MODE_ROT / MODE_VEC : encodings of the operating-mode bit
package cordic_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_QUAD = 3'd2,
    S_ITER = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

endpackage

// File: rtl/cordic_iter_cnt.sv
// cordic_iter_cnt: micro-rotation index counter.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : force count to 0 (takes priority over en_i)
//   en_i     : advance one step; wraps to 0 after the last index
//   cnt_o    : current iteration index
//   tc_o     : terminal count, high when cnt_o == n_iterations-1
module cordic_iter_cnt #(
  parameter int n_iterations = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_i,
  input  logic                            en_i,
  output logic [$clog2(n_iterations)-1:0] cnt_o,
  output logic                            tc_o
);

  localparam int CW = $clog2(n_iterations);
  localparam logic [CW-1:0] LAST = CW'(n_iterations - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  // Wrapping at the terminal count both clears the counter for the next
  // operation and guarantees it never runs past the LUT depth.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cordic_ctrl.sv
// cordic_ctrl: sequencer for the iterative CORDIC datapath.
// Optional feature macro: CORDIC_CTRL_QUAD_EN (adds QUAD state and the
// quad_corr port for a +/-90 degree pre-rotation cycle).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : operation request, only accepted in IDLE
//   mode       : 0 rotation / 1 vectoring, sampled with start
//   busy       : state != IDLE
//   load       : one-cycle datapath load pulse
//   iter_en    : one micro-rotation this cycle
//   lut_raddr  : iteration index (LUT address / shift amount), 0 outside ITER
//   mode_q     : mode latched at the accepted start
//   done       : one-cycle completion pulse
//   quad_corr  : one-cycle pre-rotation pulse (macro builds only)
// All outputs decode registered state; start has no combinational path out.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int n_iterations = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            mode,
  output logic                            busy,
  output logic                            load,
  output logic                            iter_en,
  output logic [$clog2(n_iterations)-1:0] lut_raddr,
  output logic                            mode_q,
`ifdef CORDIC_CTRL_QUAD_EN
  output logic                            quad_corr,
`endif
  output logic                            done
);

  localparam int CW = $clog2(n_iterations);

  // DATA_WIDTH is carried for the wrapper only; sanity-check parameters.
  generate
    if (DATA_WIDTH < 1 || n_iterations < 2) begin : g_bad_param
      $error("cordic_ctrl: DATA_WIDTH must be >= 1 and n_iterations >= 2");
    end
  endgenerate

  state_e        state_q, state_d;
  logic          mode_lat_q, mode_lat_d;
  logic [CW-1:0] cnt;
  logic          cnt_tc;

  cordic_iter_cnt #(.n_iterations(n_iterations)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == S_LOAD),
    .en_i  (state_q == S_ITER),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  // State and latched mode register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_lat_q <= MODE_ROT;
    end else begin
      state_q    <= state_d;
      mode_lat_q <= mode_lat_d;
    end
  end

  // Next-state logic; start/mode are only looked at in IDLE
  always_comb begin
    state_d    = state_q;
    mode_lat_d = mode_lat_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_LOAD;
        mode_lat_d = mode;
      end
`ifdef CORDIC_CTRL_QUAD_EN
      S_LOAD: state_d = S_QUAD;
      S_QUAD: state_d = S_ITER;
`else
      S_LOAD: state_d = S_ITER;
`endif
      S_ITER: if (cnt_tc) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state_q != S_IDLE);
    load      = (state_q == S_LOAD);
    iter_en   = (state_q == S_ITER);
    done      = (state_q == S_DONE);
    lut_raddr = (state_q == S_ITER) ? cnt : '0;
    mode_q    = mode_lat_q;
`ifdef CORDIC_CTRL_QUAD_EN
    quad_corr = (state_q == S_QUAD);
`endif
  end

endmodule

// File: tb/tb_cordic_ctrl.sv
// tb_cordic_ctrl: directed bench with a per-cycle output scoreboard.
// Each accepted start pushes the full expected output sequence of the
// operation; every cycle pops one entry (or expects idle) and compares.
module tb_cordic_ctrl;

  localparam int N  = 15;
  localparam int AW = $clog2(N);
`ifdef CORDIC_CTRL_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif

  typedef struct packed {
    logic          busy;
    logic          load;
    logic          iter;
    logic [AW-1:0] addr;
    logic          mq;
    logic          done;
    logic          quad;
  } ov_t;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic busy, load, iter_en, mode_q, done, quad_obs;
  logic [AW-1:0] lut_raddr;

  always #5 clk = ~clk;

`ifdef CORDIC_CTRL_QUAD_EN
  logic quad_corr;
  assign quad_obs = quad_corr;
`else
  assign quad_obs = 1'b0;
`endif

  cordic_ctrl #(.DATA_WIDTH(16), .n_iterations(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .load      (load),
    .iter_en   (iter_en),
    .lut_raddr (lut_raddr),
    .mode_q    (mode_q),
`ifdef CORDIC_CTRL_QUAD_EN
    .quad_corr (quad_corr),
`endif
    .done      (done)
  );

  ov_t q[$];
  logic exp_mq;
  bit   cur_busy;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  function automatic ov_t mk(logic b, logic l, logic it, logic [AW-1:0] a,
                             logic m, logic d, logic qd);
    ov_t e;
    e.busy = b; e.load = l; e.iter = it; e.addr = a;
    e.mq = m; e.done = d; e.quad = qd;
    return e;
  endfunction

  task automatic push_op(input logic m);
    q.push_back(mk(1, 1, 0, '0, m, 0, 0));
    if (QUAD) q.push_back(mk(1, 0, 0, '0, m, 0, 1));
    for (int i = 0; i < N; i++) q.push_back(mk(1, 0, 1, AW'(i), m, 0, 0));
    q.push_back(mk(1, 0, 0, '0, m, 1, 0));
  endtask

  // Model the edge using the inputs currently driven, advance one clock,
  // then compare the DUT outputs of the new cycle against the scoreboard.
  task automatic step(input string tag);
    ov_t e, o;
    if (rst) begin
      q.delete();
      exp_mq = 1'b0;
    end else if (!cur_busy && start) begin
      exp_mq = mode;
      push_op(mode);
    end
    @(posedge clk); #1;
    cyc++;
    if (q.size() != 0) begin
      e = q.pop_front();
      cur_busy = 1'b1;
    end else begin
      e = mk(0, 0, 0, '0, exp_mq, 0, 0);
      cur_busy = 1'b0;
    end
    o = mk(busy, load, iter_en, lut_raddr, mode_q, done, quad_obs);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed{busy,load,iter,addr,mq,done,quad}=%b_%b_%b_%h_%b_%b_%b expected=%b_%b_%b_%h_%b_%b_%b",
             tag, cyc, o.busy, o.load, o.iter, o.addr, o.mq, o.done, o.quad,
             e.busy, e.load, e.iter, e.addr, e.mq, e.done, e.quad);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    exp_mq = 1'b0; cur_busy = 1'b0;

    // Reset held for three cycles, start/mode active to prove reset priority
    start = 1'b1; mode = 1'b1;
    repeat (3) step("reset");
    rst = 1'b0; start = 1'b0; mode = 1'b0;
    repeat (2) step("idle");

    // Single vectoring op from a one-cycle start pulse
    start = 1'b1; mode = 1'b1;
    step("single_load");
    start = 1'b0; mode = 1'b0;
    repeat (N + 4) step("single_op");

    // start held continuously with mode toggling every cycle: back-to-back
    // ops spaced n+3 cycles, mode_q frozen at the accepted start edge
    start = 1'b1;
    for (int k = 0; k < 2 * (N + 3) + 5; k++) begin
      mode = k[0];
      step("start_held");
    end
    start = 1'b0; mode = 1'b0;
    repeat (N + 4) step("drain");

    // Reset while lut_raddr == 7: abandoned op, no done afterwards
    start = 1'b1; mode = 1'b1;
    step("rst_op_load");
    start = 1'b0;
    for (int k = 0; k < 8 + (QUAD ? 1 : 0); k++) step("rst_op_iter");
    rst = 1'b1;
    step("mid_iter_reset");
    rst = 1'b0;
    repeat (N + 4) step("after_reset");

    // Full op after the abandoned one, rotation mode
    start = 1'b1; mode = 1'b0;
    step("post_rst_load");
    start = 1'b0; mode = 1'b1;
    repeat (N + 4) step("post_rst_op");

    // Vectoring op, then rotation op: mode_q holds in IDLE then updates
    start = 1'b1; mode = 1'b1;
    step("vec_load");
    start = 1'b0;
    repeat (N + 3) step("vec_op");
    start = 1'b1; mode = 1'b0;
    step("rot_load");
    start = 1'b0; mode = 1'b1;
    repeat (N + 4) step("rot_op");

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain observed=%0d entries left required=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
